decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, flow-controlled RV32I decode stage between fetch and rename/dispatch.
- Decodes one instruction per cycle into register indices, a sign-extended immediate and control fields.
- Holds results in a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Adds JALR/AUIPC decode, illegal-opcode flagging, funct passthrough and pipeline flush.

Parameters:
- XLEN, 32, instruction and immediate width.
- PC_WIDTH, 9, width of i_pc / o_pc.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all held and incoming entries
- instruction  input  XLEN  instruction word, sampled on accept
- i_pc  input  PC_WIDTH  PC of instruction
- i_valid  input  1  upstream valid
- o_ready  output  1  ready to upstream
- o_valid  output  1  valid to downstream
- i_ready  input  1  ready from downstream
- o_pc  output  PC_WIDTH  PC of head entry
- rs1, rs2, rd  output  5 each  register indices
- immediate  output  XLEN  sign-extended immediate
- funct3  output  3  instr[14:12]
- funct7_5  output  1  instr[30]
- ALUsrc, Branch, Memread, Memwrite, Regwrite  output  1 each  control bits
- ALUOp  output  2  operation class
- FUtype  output  2  functional unit: 00 ALU, 01 branch, 10 LSU
- illegal  output  1  unsupported opcode

Behaviour:
Reset and latency
- Reset (rst_n low, asynchronous): both buffer entries invalid. o_valid=0, o_ready=1, every data/control output 0.
- Accept when i_valid && o_ready. The decoded entry appears at the outputs the next cycle: 1-cycle latency, 1/cycle throughput.

Skid buffer
- Head register drives the outputs; the skid register holds overflow.
- Head is empty, or head pops (i_ready && o_valid): the new entry goes to head, or the skid entry moves to head while the new entry goes to skid.
- Head is stalled and skid is empty: the new entry goes to skid.
- o_ready = !skid_valid, registered; no combinational path from i_ready.
- Order is strictly FIFO. Simultaneous pop and accept with a full skid cannot occur, because o_ready=0 then.

Flush
- Next cycle both entries are invalid and o_valid=0.
- Any accept in the flush cycle is discarded; o_ready returns to 1 the next cycle.
- Flush dominates pop and accept.

Decode table (opcode -> ALUsrc, Branch, ALUOp, FUtype, Memread, Memwrite, Regwrite)
- 0110011 R: 0,0,10,00,0,0,1
- 0010011 I-ALU: 1,0,10,00,0,0,1
- 0000011 load: 1,0,00,10,1,0,1
- 0100011 store: 1,0,00,10,0,1,0
- 1100011 branch: 0,1,01,01,0,0,0
- 0110111 LUI: 1,0,11,00,0,0,1
- 0010111 AUIPC: 1,0,11,01,0,0,1. Branch unit adds PC.
- 1101111 JAL: 1,1,01,01,0,0,1
- 1100111 JALR: 1,1,01,01,0,0,1
- Other opcode: illegal=1, all control bits 0, FUtype 00. The entry still flows through the buffer.

Immediates
- I, S, B, U, J per RV32I, sign-extended from the instruction MSB.
- B and J immediates are byte offsets with bit0=0.
- U immediate = instr[31:12]<<12.
- R-type immediate = 0.

Field extraction
- rs1, rs2, rd, funct3 and funct7_5 are always raw bit fields, regardless of type.

Test Plan:
- Reset with rst_n=0 mid-stream holding 2 entries -> same cycle o_valid=0, o_ready=1, immediate=0; after release, the next accept has 1-cycle latency.
- ADD x5,x6,x7 (0x007302B3), pc 0x100, i_ready=1 -> next cycle o_valid=1, rs1=6, rs2=7, rd=5, ALUOp=10, FUtype=00, Regwrite=1, o_pc=0x100.
- Back-to-back ADDI x5,x6,-10 / SW x7,24(x6) / BEQ x5,x6,8 with i_ready held 0 for 3 cycles -> o_ready drops after 2 accepts; outputs stay on ADDI (imm 0xFFFFFFF6); on release they emerge in order with imm 24, then 8; nothing lost or duplicated.
- JAL x1,20 then JALR x0,0(x1) then AUIPC x5,0x12345 -> imm 20 / 0 / 0x12345000, FUtype=01 for all, Branch=1 / 1 / 0.
- Opcode 0000000 -> illegal=1, Regwrite=0, Memread=0, Memwrite=0, o_valid=1.
- Flush asserted with both entries full and i_valid=1 -> next cycle o_valid=0, o_ready=1; the flushed instructions never appear at the outputs.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-side and dispatch-side signal bundle for the RV32I decode stage.
// The master modport is the environment; the slave modport is the stage.
interface decode_stage_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 9
);
    logic [XLEN-1:0]     instruction;
    logic [PC_WIDTH-1:0] i_pc;
    logic                i_valid;
    logic                o_ready;
    logic                o_valid;
    logic                i_ready;
    logic [PC_WIDTH-1:0] o_pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN-1:0]     immediate;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic                ALUsrc;
    logic                Branch;
    logic                Memread;
    logic                Memwrite;
    logic                Regwrite;
    logic [1:0]          ALUOp;
    logic [1:0]          FUtype;
    logic                illegal;

    modport master (
        output instruction, i_pc, i_valid, i_ready,
        input  o_ready, o_valid, o_pc, rs1, rs2, rd, immediate,
        input  funct3, funct7_5, ALUsrc, Branch, Memread, Memwrite,
        input  Regwrite, ALUOp, FUtype, illegal
    );

    modport slave (
        input  instruction, i_pc, i_valid, i_ready,
        output o_ready, o_valid, o_pc, rs1, rs2, rd, immediate,
        output funct3, funct7_5, ALUsrc, Branch, Memread, Memwrite,
        output Regwrite, ALUOp, FUtype, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer.
// Upstream ready is a flop, so it never depends on downstream ready.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
        logic [2:0]          funct3;
        logic                funct7_5;
        logic                alusrc;
        logic                branch;
        logic                memread;
        logic                memwrite;
        logic                regwrite;
        logic [1:0]          aluop;
        logic [1:0]          futype;
        logic                illegal;
    } entry_t;

    entry_t          dec;
    entry_t          head_q;
    entry_t          skid_q;
    logic            head_v;
    logic            skid_v;
    logic            accept;
    logic            pop;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign ins   = bus.instruction;
    assign imm_i = XLEN'($signed(ins[31:20]));
    assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
    assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25],
                                  ins[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20],
                                  ins[30:21], 1'b0}));

    always_comb begin
        dec          = '0;
        dec.pc       = bus.i_pc;
        dec.rs1      = ins[19:15];
        dec.rs2      = ins[24:20];
        dec.rd       = ins[11:7];
        dec.funct3   = ins[14:12];
        dec.funct7_5 = ins[30];
        unique case (ins[6:0])
            7'b0110011: begin
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
            end
            7'b0010011: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
                dec.imm      = imm_i;
            end
            7'b0000011: begin
                dec.alusrc   = 1'b1;
                dec.futype   = 2'b10;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = imm_i;
            end
            7'b0100011: begin
                dec.alusrc   = 1'b1;
                dec.futype   = 2'b10;
                dec.memwrite = 1'b1;
                dec.imm      = imm_s;
            end
            7'b1100011: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b01;
                dec.futype = 2'b01;
                dec.imm    = imm_b;
            end
            7'b0110111: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b11;
                dec.regwrite = 1'b1;
                dec.imm      = imm_u;
            end
            // AUIPC goes to the branch unit, which owns the PC adder
            7'b0010111: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b11;
                dec.futype   = 2'b01;
                dec.regwrite = 1'b1;
                dec.imm      = imm_u;
            end
            7'b1101111: begin
                dec.alusrc   = 1'b1;
                dec.branch   = 1'b1;
                dec.aluop    = 2'b01;
                dec.futype   = 2'b01;
                dec.regwrite = 1'b1;
                dec.imm      = imm_j;
            end
            7'b1100111: begin
                dec.alusrc   = 1'b1;
                dec.branch   = 1'b1;
                dec.aluop    = 2'b01;
                dec.futype   = 2'b01;
                dec.regwrite = 1'b1;
                dec.imm      = imm_i;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign accept = bus.i_valid && !skid_v;
    assign pop    = head_v && bus.i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!head_v || pop) begin
            // a full skid blocks accept, so it simply drains into head
            if (skid_v) begin
                head_q <= skid_q;
                head_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                head_v <= accept;
                if (accept) head_q <= dec;
            end
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign bus.o_valid   = head_v;
    assign bus.o_ready   = !skid_v;
    assign bus.o_pc      = head_q.pc;
    assign bus.rs1       = head_q.rs1;
    assign bus.rs2       = head_q.rs2;
    assign bus.rd        = head_q.rd;
    assign bus.immediate = head_q.imm;
    assign bus.funct3    = head_q.funct3;
    assign bus.funct7_5  = head_q.funct7_5;
    assign bus.ALUsrc    = head_q.alusrc;
    assign bus.Branch    = head_q.branch;
    assign bus.Memread   = head_q.memread;
    assign bus.Memwrite  = head_q.memwrite;
    assign bus.Regwrite  = head_q.regwrite;
    assign bus.ALUOp     = head_q.aluop;
    assign bus.FUtype    = head_q.futype;
    assign bus.illegal   = head_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random
// traffic scored against a queue-based reference of the decode rules.
module tb_decode_stage;
    typedef struct packed {
        logic [8:0]  pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f75;
        logic [9:0]  ctrl;
        logic        ill;
    } ent_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_pass;
    ent_t q[$];

    decode_stage_if #(.XLEN(32), .PC_WIDTH(9)) bus ();

    decode_stage #(.XLEN(32), .PC_WIDTH(9)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic ent_t ref_decode(input logic [31:0] ins,
                                        input logic [8:0] pc);
        ent_t e;
        int   iv, sv, bv, jv;
        bit   neg;
        e     = '0;
        e.pc  = pc;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.f3  = ins[14:12];
        e.f75 = ins[30];
        neg   = ins[31];
        iv = int'(ins >> 20);
        sv = int'(((ins >> 25) << 5) | ((ins >> 7) & 31));
        bv = int'(((ins >> 7) & 1) * 2048 + ((ins >> 25) & 63) * 32
                  + ((ins >> 8) & 15) * 2);
        jv = int'(((ins >> 12) & 255) * 4096 + ((ins >> 20) & 1) * 2048
                  + ((ins >> 21) & 1023) * 2);
        if (neg) begin
            iv -= 4096;
            sv -= 4096;
            bv -= 4096;
            jv -= (1 << 20);
        end
        // ctrl = {ALUsrc, Branch, ALUOp, FUtype, Memread, Memwrite, Regwrite}
        case (ins[6:0])
            7'h33: e.ctrl = 10'b0_0_10_00_0_0_1;
            7'h13: begin e.ctrl = 10'b1_0_10_00_0_0_1; e.imm = iv; end
            7'h03: begin e.ctrl = 10'b1_0_00_10_1_0_1; e.imm = iv; end
            7'h23: begin e.ctrl = 10'b1_0_00_10_0_1_0; e.imm = sv; end
            7'h63: begin e.ctrl = 10'b0_1_01_01_0_0_0; e.imm = bv; end
            7'h37: begin
                e.ctrl = 10'b1_0_11_00_0_0_1;
                e.imm  = ins & 32'hFFFF_F000;
            end
            7'h17: begin
                e.ctrl = 10'b1_0_11_01_0_0_1;
                e.imm  = ins & 32'hFFFF_F000;
            end
            7'h6F: begin e.ctrl = 10'b1_1_01_01_0_0_1; e.imm = jv; end
            7'h67: begin e.ctrl = 10'b1_1_01_01_0_0_1; e.imm = iv; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic ent_t dut_entry();
        ent_t e;
        e.pc   = bus.o_pc;
        e.rs1  = bus.rs1;
        e.rs2  = bus.rs2;
        e.rd   = bus.rd;
        e.imm  = bus.immediate;
        e.f3   = bus.funct3;
        e.f75  = bus.funct7_5;
        e.ctrl = {bus.ALUsrc, bus.Branch, bus.ALUOp, bus.FUtype,
                  bus.Memread, bus.Memwrite, bus.Regwrite};
        e.ill  = bus.illegal;
        return e;
    endfunction

    // Drive one cycle of inputs and advance the reference queue.
    task automatic cyc(input logic f, input logic v, input logic [31:0] ins,
                       input logic [8:0] pc, input logic rdy);
        bit mready;
        bus.instruction = ins;
        bus.i_pc        = pc;
        bus.i_valid     = v;
        bus.i_ready     = rdy;
        flush           = f;
        mready          = q.size() < 2;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (v && mready) q.push_back(ref_decode(ins, pc));
        end
        #1;
        flush       = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
            $display("FAIL reset_hs got %b want 01",
                     {bus.o_valid, bus.o_ready});
        end else n_pass++;
        n_checks++;
        if (dut_entry() !== ent_t'(0)) begin
            $display("FAIL reset_data got %h want 0", dut_entry());
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_add();
        cyc(0, 1, 32'h007302B3, 9'h100, 1);
        n_checks++;
        if (bus.o_valid !== 1'b1 || {bus.rs1, bus.rs2, bus.rd} !==
            {5'd6, 5'd7, 5'd5}) begin
            $display("FAIL add_regs got v=%b %0d %0d %0d want 1 6 7 5",
                     bus.o_valid, bus.rs1, bus.rs2, bus.rd);
        end else n_pass++;
        n_checks++;
        if ({bus.ALUOp, bus.FUtype, bus.Regwrite, bus.o_pc} !==
            {2'b10, 2'b00, 1'b1, 9'h100}) begin
            $display("FAIL add_ctrl got %b %b %b %h want 10 00 1 100",
                     bus.ALUOp, bus.FUtype, bus.Regwrite, bus.o_pc);
        end else n_pass++;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        cyc(0, 1, 32'hFF630293, 9'h010, 0);
        cyc(0, 1, 32'h00732C23, 9'h014, 0);
        n_checks++;
        if (bus.o_ready !== 1'b0 || bus.immediate !== 32'hFFFF_FFF6) begin
            $display("FAIL b2b_full got rdy=%b imm=%h want 0 fffffff6",
                     bus.o_ready, bus.immediate);
        end else n_pass++;
        cyc(0, 1, 32'h00628463, 9'h018, 0);
        n_checks++;
        if (bus.o_pc !== 9'h010 || bus.o_ready !== 1'b0) begin
            $display("FAIL b2b_hold got pc=%h rdy=%b want 010 0",
                     bus.o_pc, bus.o_ready);
        end else n_pass++;
        cyc(0, 1, 32'h00628463, 9'h018, 1);
        n_checks++;
        if (bus.immediate !== 32'd24 || bus.o_pc !== 9'h014 ||
            bus.o_ready !== 1'b1) begin
            $display("FAIL b2b_sw got imm=%h pc=%h rdy=%b want 18 014 1",
                     bus.immediate, bus.o_pc, bus.o_ready);
        end else n_pass++;
        cyc(0, 1, 32'h00628463, 9'h018, 1);
        n_checks++;
        if (bus.immediate !== 32'd8 || bus.o_pc !== 9'h018 ||
            bus.Branch !== 1'b1) begin
            $display("FAIL b2b_beq got imm=%h pc=%h br=%b want 8 018 1",
                     bus.immediate, bus.o_pc, bus.Branch);
        end else n_pass++;
        cyc(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            $display("FAIL b2b_drain got v=%b want 0", bus.o_valid);
        end else n_pass++;
    endtask

    task automatic test_jumps();
        cyc(0, 1, 32'h014000EF, 9'h020, 1);
        n_checks++;
        if ({bus.immediate, bus.FUtype, bus.Branch} !==
            {32'd20, 2'b01, 1'b1}) begin
            $display("FAIL jal got imm=%h fu=%b br=%b want 14 01 1",
                     bus.immediate, bus.FUtype, bus.Branch);
        end else n_pass++;
        cyc(0, 1, 32'h00008067, 9'h024, 1);
        n_checks++;
        if ({bus.immediate, bus.FUtype, bus.Branch, bus.rs1} !==
            {32'd0, 2'b01, 1'b1, 5'd1}) begin
            $display("FAIL jalr got imm=%h fu=%b br=%b rs1=%0d want 0 01 1 1",
                     bus.immediate, bus.FUtype, bus.Branch, bus.rs1);
        end else n_pass++;
        cyc(0, 1, 32'h12345297, 9'h028, 1);
        n_checks++;
        if ({bus.immediate, bus.FUtype, bus.Branch} !==
            {32'h1234_5000, 2'b01, 1'b0}) begin
            $display("FAIL auipc got imm=%h fu=%b br=%b want 12345000 01 0",
                     bus.immediate, bus.FUtype, bus.Branch);
        end else n_pass++;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_illegal();
        cyc(0, 1, 32'h0000_0000, 9'h030, 1);
        n_checks++;
        if ({bus.o_valid, bus.illegal, bus.Regwrite, bus.Memread,
             bus.Memwrite} !== 5'b11000) begin
            $display("FAIL illegal got %b want 11000",
                     {bus.o_valid, bus.illegal, bus.Regwrite, bus.Memread,
                      bus.Memwrite});
        end else n_pass++;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_flush();
        cyc(0, 1, 32'h007302B3, 9'h040, 0);
        cyc(1, 1, 32'h00628463, 9'h044, 0);
        n_checks++;
        if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
            $display("FAIL flush_one got %b want 01",
                     {bus.o_valid, bus.o_ready});
        end else n_pass++;
        cyc(0, 1, 32'h007302B3, 9'h048, 0);
        cyc(0, 1, 32'h00732C23, 9'h04C, 0);
        cyc(1, 1, 32'h00628463, 9'h050, 0);
        n_checks++;
        if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
            $display("FAIL flush_full got %b want 01",
                     {bus.o_valid, bus.o_ready});
        end else n_pass++;
        cyc(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            $display("FAIL flush_gone got v=%b want 0", bus.o_valid);
        end else n_pass++;
    endtask

    task automatic test_reset_midstream();
        cyc(0, 1, 32'hFF630293, 9'h060, 0);
        cyc(0, 1, 32'h00732C23, 9'h064, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_valid, bus.o_ready} !== 2'b01 ||
            bus.immediate !== 32'd0) begin
            $display("FAIL rst_mid got v=%b r=%b imm=%h want 0 1 0",
                     bus.o_valid, bus.o_ready, bus.immediate);
        end else n_pass++;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 1, 32'h007302B3, 9'h070, 0);
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.rd !== 5'd5 ||
            bus.o_pc !== 9'h070) begin
            $display("FAIL rst_lat got v=%b rd=%0d pc=%h want 1 5 070",
                     bus.o_valid, bus.rd, bus.o_pc);
        end else n_pass++;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [6:0]  ops[10];
        logic [31:0] r;
        logic [6:0]  op;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
        for (int i = 0; i < 400; i++) begin
            n_checks++;
            if (bus.o_valid !== (q.size() > 0) ||
                bus.o_ready !== (q.size() < 2)) begin
                $display("FAIL rnd_hs cyc %0d got v=%b r=%b want occ %0d",
                         i, bus.o_valid, bus.o_ready, q.size());
            end else n_pass++;
            if (q.size() > 0) begin
                n_checks++;
                if (dut_entry() !== q[0]) begin
                    $display("FAIL rnd_data cyc %0d got %h want %h",
                             i, dut_entry(), q[0]);
                end else n_pass++;
            end
            r = $urandom();
            if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 8)];
            else op = r[6:0];
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
                {r[31:7], op}, 9'($urandom()), $urandom_range(0, 9) < 6);
        end
    endtask

    initial begin
        clk             = 1'b0;
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.instruction = '0;
        bus.i_pc        = '0;
        bus.i_valid     = 1'b0;
        bus.i_ready     = 1'b0;
        n_checks        = 0;
        n_pass          = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_jumps();
        test_illegal();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
